// File: rtl/xc20xx_cfg_loader.sv
// Byte-serial XC20XX configuration loader: hunts for the sync byte, takes a word count,
// then writes one little-endian 32-bit word per CLB. Optional XOR trailer: XC20XX_CFG_CHECKSUM_EN.
module xc20xx_cfg_loader #(
    parameter int          NUM_CLB = 64,
    parameter int          ADDR_W  = 6,
    parameter logic [7:0]  SYNC    = 8'hB2
) (
    input  logic              K,
    input  logic              R_N,
    input  logic              START,
    input  logic [7:0]        IN_DATA,
    input  logic              IN_VLD,
    output logic              IN_RDY,
    output logic [ADDR_W-1:0] CFG_ADDR,
    output logic [31:0]       CFG_DATA,
    output logic              CFG_WE,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_COUNT,
        S_DATA,
`ifdef XC20XX_CFG_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic                busy;
    logic                xfer;
    logic                count_bad;
    logic                last_byte;
    logic [1:0]          bidx_q;
    logic [ADDR_W-1:0]   widx_q;
    logic [ADDR_W-1:0]   last_q;
    logic [23:0]         asm_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic                done_q;
    logic                err_q;
`ifdef XC20XX_CFG_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    assign xfer      = IN_VLD & IN_RDY;
    assign count_bad = (IN_DATA == 8'd0) || (int'(IN_DATA) > NUM_CLB);
    assign last_byte = (bidx_q == 2'd3) && (widx_q == last_q);

    always_ff @(posedge K or negedge R_N) begin
        if (!R_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        unique case (state_q)
            S_SYNC, S_COUNT, S_DATA: busy = 1'b1;
`ifdef XC20XX_CFG_CHECKSUM_EN
            S_CSUM:                  busy = 1'b1;
`endif
            default:                 busy = 1'b0;
        endcase

        if (START) begin
            state_d = S_SYNC;
        end else if (xfer) begin
            unique case (state_q)
                S_SYNC: begin
                    if (IN_DATA == SYNC) state_d = S_COUNT;
                end
                S_COUNT: begin
                    state_d = count_bad ? S_ERR : S_DATA;
                end
                S_DATA: begin
                    if (last_byte) begin
`ifdef XC20XX_CFG_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end
                end
`ifdef XC20XX_CFG_CHECKSUM_EN
                S_CSUM: begin
                    state_d = (IN_DATA == csum_q) ? S_DONE : S_ERR;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    assign BUSY   = busy;
    assign IN_RDY = busy & ~START;

    // Write strobe is registered, so a START arriving in the strobe cycle cannot cancel it.
    always_ff @(posedge K or negedge R_N) begin
        if (!R_N) begin
            bidx_q <= '0;
            widx_q <= '0;
            last_q <= '0;
            asm_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef XC20XX_CFG_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (START) begin
                bidx_q <= '0;
                widx_q <= '0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
`ifdef XC20XX_CFG_CHECKSUM_EN
                csum_q <= '0;
`endif
            end else begin
                if (xfer && state_q == S_COUNT) begin
                    last_q <= ADDR_W'(IN_DATA - 8'd1);
                    widx_q <= '0;
                    bidx_q <= '0;
                end
                if (xfer && state_q == S_DATA) begin
`ifdef XC20XX_CFG_CHECKSUM_EN
                    csum_q <= csum_q ^ IN_DATA;
`endif
                    bidx_q <= bidx_q + 2'd1;
                    unique case (bidx_q)
                        2'd0: asm_q[7:0]   <= IN_DATA;
                        2'd1: asm_q[15:8]  <= IN_DATA;
                        2'd2: asm_q[23:16] <= IN_DATA;
                        default: begin
                            we_q   <= 1'b1;
                            addr_q <= widx_q;
                            data_q <= {IN_DATA, asm_q};
                            widx_q <= widx_q + ADDR_W'(1);
                        end
                    endcase
                end
                if (xfer && state_d == S_ERR) begin
                    err_q <= 1'b1;
                end
`ifdef XC20XX_CFG_CHECKSUM_EN
                if (xfer && state_q == S_CSUM && IN_DATA == csum_q) begin
                    done_q <= 1'b1;
                end
`else
                // DONE trails the final write strobe by one cycle.
                if (state_q == S_DONE) begin
                    done_q <= 1'b1;
                end
`endif
            end
        end
    end

    assign CFG_WE   = we_q;
    assign CFG_ADDR = addr_q;
    assign CFG_DATA = data_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Randomized bench for xc20xx_cfg_loader; builds frames as byte queues and predicts the
// written words and final flags by parsing the frame directly.
module tb_xc20xx_cfg_loader;

    localparam int         NUM_CLB = 64;
    localparam int         ADDR_W  = 6;
    localparam logic [7:0] SYNC    = 8'hB2;

    logic              K = 1'b0;
    logic              R_N = 1'b0;
    logic              START = 1'b0;
    logic [7:0]        IN_DATA = 8'h00;
    logic              IN_VLD = 1'b0;
    logic              IN_RDY;
    logic [ADDR_W-1:0] CFG_ADDR;
    logic [31:0]       CFG_DATA;
    logic              CFG_WE;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    int checks = 0;
    int errors = 0;

    logic [7:0]  strm[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic        exp_done;
    logic        exp_err;
    int          n_cons;

    xc20xx_cfg_loader #(.NUM_CLB(NUM_CLB), .ADDR_W(ADDR_W), .SYNC(SYNC)) dut (
        .K(K), .R_N(R_N), .START(START), .IN_DATA(IN_DATA), .IN_VLD(IN_VLD),
        .IN_RDY(IN_RDY), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .CFG_WE(CFG_WE),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 K = ~K;

    always @(negedge K) begin
        if (CFG_WE === 1'b1) begin
            got_addr.push_back(32'(CFG_ADDR));
            got_data.push_back(CFG_DATA);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: parse the frame per the protocol rules (hunt, count, words, optional xor).
    task automatic model_run();
        int i;
        int n;
        logic [7:0] cs;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        cs = 8'h00;
        i = 0;
        while (i < strm.size() && strm[i] != SYNC) i++;
        if (i + 1 >= strm.size()) begin
            n_cons = strm.size();
            return;
        end
        n = 32'(strm[i+1]);
        i += 2;
        if (n == 0 || n > NUM_CLB) begin
            exp_err = 1'b1;
            n_cons  = i;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(32'(w));
            exp_data.push_back({strm[i+3], strm[i+2], strm[i+1], strm[i]});
            for (int b = 0; b < 4; b++) cs = cs ^ strm[i+b];
            i += 4;
        end
`ifdef XC20XX_CFG_CHECKSUM_EN
        exp_done = (strm[i] == cs);
        exp_err  = !exp_done;
        n_cons   = i + 1;
`else
        exp_done = 1'b1;
        n_cons   = i;
`endif
    endtask

    task automatic add_csum(input int first);
`ifdef XC20XX_CFG_CHECKSUM_EN
        logic [7:0] cs;
        cs = 8'h00;
        for (int j = first; j < strm.size(); j++) cs = cs ^ strm[j];
        strm.push_back(cs);
`else
        if (first < 0) $display("note: negative checksum start");
`endif
    endtask

    task automatic build_frame(input int n, input int junk);
        logic [7:0] b;
        strm.delete();
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom);
            strm.push_back((b == SYNC) ? 8'h00 : b);
        end
        strm.push_back(SYNC);
        strm.push_back(8'(n));
        for (int j = 0; j < 4 * n; j++) strm.push_back(8'($urandom));
        add_csum(junk + 2);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge K);
        chk("rdy_during_start", 32'(IN_RDY), 32'd0);
        @(posedge K);
        #1;
        START = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        int k;
        logic rdy;
        for (int j = lo; j < hi; j++) begin
            if (gaps) begin
                IN_VLD = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge K);
                    #1;
                end
            end
            IN_VLD  = 1'b1;
            IN_DATA = strm[j];
            k = 0;
            rdy = 1'b0;
            while (!rdy && k < 64) begin
                @(negedge K);
                rdy = IN_RDY;
                k++;
            end
            if (!rdy) begin
                chk("rdy_timeout", 32'd0, 32'd1);
                IN_VLD = 1'b0;
                return;
            end
            @(posedge K);
            #1;
            IN_VLD = 1'b0;
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
            chk({tag, "_addr"}, got_addr[k], exp_addr[k]);
            chk({tag, "_data"}, got_data[k], exp_data[k]);
        end
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit do_start);
        model_run();
        got_addr.delete();
        got_data.delete();
        if (do_start) pulse_start();
        send_range(0, n_cons, gaps);
        if (exp_done) begin
`ifdef XC20XX_CFG_CHECKSUM_EN
            @(negedge K);
            chk({tag, "_done_after_csum"}, 32'(DONE), 32'd1);
`else
            @(negedge K);
            chk({tag, "_last_we"}, 32'(CFG_WE), 32'd1);
            chk({tag, "_done_early"}, 32'(DONE), 32'd0);
            @(negedge K);
            chk({tag, "_done_next"}, 32'(DONE), 32'd1);
`endif
        end
        repeat (3) @(negedge K);
        check_writes(tag);
        chk({tag, "_done"}, 32'(DONE), 32'(exp_done));
        chk({tag, "_err"}, 32'(ERR), 32'(exp_err));
        chk({tag, "_rdy_end"}, 32'(IN_RDY), 32'd0);
        chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
        @(posedge K);
        #1;
    endtask

    initial begin
        logic [31:0] w0;

        // Reset values
        repeat (2) @(negedge K);
        chk("rst_rdy", 32'(IN_RDY), 32'd0);
        chk("rst_we", 32'(CFG_WE), 32'd0);
        chk("rst_addr", 32'(CFG_ADDR), 32'd0);
        chk("rst_data", CFG_DATA, 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        @(posedge K);
        #1;
        R_N = 1'b1;
        IN_VLD = 1'b1;
        @(negedge K);
        chk("idle_rdy", 32'(IN_RDY), 32'd0);
        @(posedge K);
        #1;
        IN_VLD = 1'b0;

        // Single-word frame
        strm = {SYNC, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        add_csum(2);
        run_frame("one_word", 1'b0, 1'b1);
        chk("one_word_const", (got_data.size() > 0) ? got_data[0] : 32'hx, 32'h44332211);

        // Junk before sync
        strm = {8'h00, 8'h7F, SYNC, 8'h02};
        for (int j = 0; j < 8; j++) strm.push_back(8'($urandom));
        add_csum(4);
        run_frame("junk_two", 1'b0, 1'b1);

        // Bad counts
        strm = {SYNC, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        run_frame("count_zero", 1'b0, 1'b1);
        strm = {SYNC, 8'(NUM_CLB + 1), 8'h12, 8'h34, 8'h56, 8'h78};
        run_frame("count_over", 1'b0, 1'b1);

`ifdef XC20XX_CFG_CHECKSUM_EN
        strm = {SYNC, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        run_frame("csum_good", 1'b0, 1'b1);
        strm = {SYNC, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        run_frame("csum_bad", 1'b0, 1'b1);
`endif

        // Same 4-word frame without and with valid gaps
        build_frame(4, 1);
        run_frame("four_nogap", 1'b0, 1'b1);
        run_frame("four_gaps", 1'b1, 1'b1);

        // Random frames
        for (int r = 0; r < 6; r++) begin
            build_frame($urandom_range(1, 8), $urandom_range(0, 2));
            run_frame("rand", r[0], 1'b1);
        end

        // Largest legal frame
        build_frame(NUM_CLB, 0);
        run_frame("max_clb", 1'b0, 1'b1);

        // START mid-DATA (word 1, byte 2), then a fresh frame
        build_frame(3, 0);
        w0 = {strm[5], strm[4], strm[3], strm[2]};
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_range(0, 8, 1'b0);
        pulse_start();
        @(negedge K);
        chk("abort_busy", 32'(BUSY), 32'd1);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_nwrites", 32'(got_data.size()), 32'd1);
        chk("abort_w0", (got_data.size() > 0) ? got_data[0] : 32'hx, w0);
        @(posedge K);
        #1;
        build_frame(2, 2);
        run_frame("after_abort", 1'b1, 1'b0);

        // START in the cycle the write strobe is pending
        build_frame(2, 0);
        w0 = {strm[5], strm[4], strm[3], strm[2]};
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_range(0, 6, 1'b0);
        pulse_start();
        chk("coinc_nwrites", 32'(got_data.size()), 32'd1);
        chk("coinc_w0", (got_data.size() > 0) ? got_data[0] : 32'hx, w0);
        chk("coinc_addr", (got_addr.size() > 0) ? got_addr[0] : 32'hx, 32'd0);
        build_frame(1, 0);
        run_frame("after_coinc", 1'b0, 1'b0);

        // Asynchronous reset mid-frame
        build_frame(2, 0);
        pulse_start();
        send_range(0, 7, 1'b0);
        @(negedge K);
        #2;
        R_N = 1'b0;
        #1;
        chk("mrst_rdy", 32'(IN_RDY), 32'd0);
        chk("mrst_we", 32'(CFG_WE), 32'd0);
        chk("mrst_addr", 32'(CFG_ADDR), 32'd0);
        chk("mrst_data", CFG_DATA, 32'd0);
        chk("mrst_busy", 32'(BUSY), 32'd0);
        chk("mrst_done", 32'(DONE), 32'd0);
        chk("mrst_err", 32'(ERR), 32'd0);
        @(posedge K);
        #1;
        R_N = 1'b1;
        build_frame(3, 1);
        run_frame("after_mrst", 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
